// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(ITER_COUNT - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    logic r;
    case (funct)
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_decoded(input logic [5:0] funct);
    logic r;
    case (funct)
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1'b1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring-subtract
// steps on operand magnitudes, followed by a single sign-fixup cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] Data1_i,
  input  logic [WIDTH-1:0] Data2_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state_r, state_s;
  cnt_t               cnt_r;
  logic               mult_r, neg_res_r, neg_rem_r, div_zero_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   a_raw_r, opnd_r, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc_r, step_s, prod_fix_s;
  logic [2*WIDTH:0]   shl_s;
  logic [WIDTH:0]     mul_sum_s, div_diff_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
  logic               signed_op_s, mult_op_s, accept_s;

  assign signed_op_s = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
  assign mult_op_s   = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_MULTU);
  assign accept_s    = start_i && is_muldiv(funct_i);

  cond_neg #(.WIDTH(WIDTH)) u_mag_a (
    .neg (signed_op_s && Data1_i[WIDTH-1]), .din (Data1_i), .dout (mag_a_s)
  );
  cond_neg #(.WIDTH(WIDTH)) u_mag_b (
    .neg (signed_op_s && Data2_i[WIDTH-1]), .din (Data2_i), .dout (mag_b_s)
  );
  cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg (neg_res_r), .din (acc_r), .dout (prod_fix_s)
  );
  cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .neg (neg_res_r), .din (acc_r[WIDTH-1:0]), .dout (quo_fix_s)
  );
  cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .neg (neg_rem_r), .din (acc_r[2*WIDTH-1:WIDTH]), .dout (rem_fix_s)
  );

  // Next-state logic for the IDLE -> CALC -> FIX sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CNT_LAST) state_s = FIX;
        else                   state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    shl_s      = {acc_r, 1'b0};
    div_diff_s = shl_s[2*WIDTH:WIDTH] - {1'b0, opnd_r};
    step_s     = acc_r;
    if (mult_r) begin
      if (acc_r[0]) step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      else          step_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end else begin
      // No borrow means the shifted remainder covers the divisor.
      if (!div_diff_s[WIDTH]) step_s = {div_diff_s[WIDTH-1:0], shl_s[WIDTH-1:1], 1'b1};
      else                    step_s = shl_s[2*WIDTH-1:0];
    end
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= cnt_t'(0);
      mult_r     <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      a_raw_r    <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r      <= cnt_t'(0);
            busy_r     <= 1'b1;
            mult_r     <= mult_op_s;
            a_raw_r    <= Data1_i;
            neg_res_r  <= signed_op_s && (Data1_i[WIDTH-1] ^ Data2_i[WIDTH-1]);
            neg_rem_r  <= signed_op_s && Data1_i[WIDTH-1];
            div_zero_r <= (Data2_i == {WIDTH{1'b0}});
            opnd_r     <= mult_op_s ? mag_a_s : mag_b_s;
            acc_r      <= {{WIDTH{1'b0}}, (mult_op_s ? mag_b_s : mag_a_s)};
          end else if (start_i && (funct_i == FUNCT_MTHI)) begin
            hi_r <= Data1_i;
          end else if (start_i && (funct_i == FUNCT_MTLO)) begin
            lo_r <= Data1_i;
          end
        end
        CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (mult_r) begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end else if (div_zero_r) begin
            hi_r <= a_raw_r;
            lo_r <= {WIDTH{1'b1}};
          end else begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign hi_o    = hi_r;
  assign lo_o    = lo_r;
  assign stall_o = busy_r && start_i && is_decoded(funct_i);

endmodule
